demux1n2_stream: RTL and testbench
==================================

// Module: demux1n2_stream
// PURPOSE
//  Registered 1-to-2 demultiplexer with valid/ready handshakes. It is the
//  distributing counterpart of the 2:1 selection mux.
//  One input word stream is steered by Sel into one of two output queues.
//  Each output queue is a DEPTH-entry FIFO that drains through its own handshake.
//  It sits between a single producer and two consumers, for example a control
//  word fanned out to two datapath stages.
// PARAMETERS
//  W      2   width of the data word
//  DEPTH  2   entries per output FIFO; power of 2, >= 2
//  AW     $clog2(DEPTH)   localparam, pointer width
// PORTS
//  Clock         in   1      rising-edge clock
//  Reset         in   1      synchronous, active-high reset
//  hyrja         in   W      input data word
//  hyrja_valid   in   1      input word valid
//  hyrja_ready   out  1      block can accept the word (for the current Sel)
//  Sel           in   1      destination: 0 -> dalja0, 1 -> dalja1
//  dalja0        out  W      head word of FIFO 0
//  dalja0_valid  out  1      FIFO 0 not empty
//  dalja0_ready  in   1      consumer 0 takes the head word
//  dalja1        out  W      head word of FIFO 1
//  dalja1_valid  out  1      FIFO 1 not empty
//  dalja1_ready  in   1      consumer 1 takes the head word
//  niveli0       out  AW+1   occupancy of FIFO 0 (0..DEPTH)
//  niveli1       out  AW+1   occupancy of FIFO 1 (0..DEPTH)
// BEHAVIOUR
//  - Reset (sync, high) clears all pointers and occupancies.
//    * daljaN_valid = 0, nivelN = 0, daljaN = 0.
//    * hyrja_ready = 1 in the cycle after Reset deasserts.
//    * Reset takes priority over every push and pop in the same cycle.
//    * Words held in the FIFOs when Reset asserts are discarded.
//  - hyrja_ready is combinational: hyrja_ready = !full[Sel].
//    * It depends only on Sel and the registered occupancy.
//    * It never depends on daljaN_ready, so there is no comb path from the output handshakes.
//  - Push: when hyrja_valid && hyrja_ready at a rising edge, hyrja is written into FIFO[Sel].
//    * Sel is sampled in the same cycle as the data.
//    * Changing Sel while hyrja_valid is high and hyrja_ready is low is legal.
//    * ready re-evaluates against the new Sel.
//  - Pop: when daljaN_valid && daljaN_ready at a rising edge, the head of FIFO N is removed.
//  - Latency: a word pushed into an empty FIFO appears on daljaN with valid = 1 in the next cycle.
//    There is no same-cycle bypass.
//  - Outputs: daljaN is the memory word at the read pointer; daljaN_valid = (nivelN != 0).
//    * daljaN holds stable while valid is high and ready is low.
//    * daljaN is don't-care when valid = 0. The bench must not check it.
//  - Simultaneous push and pop on the same FIFO:
//    * Not empty and not full: occupancy is unchanged and both pointers advance.
//    * Full: the push is refused (ready = 0) and the pop proceeds.
//      Occupancy becomes DEPTH-1, and ready rises in the next cycle.
//    * Empty: only the push happens, because valid = 0 blocks the pop.
//  - The two FIFOs are independent. A push to one FIFO and a pop from the other may
//    happen in the same cycle.
//  - Pointers are AW bits wide and wrap modulo DEPTH. Occupancy is AW+1 bits, with range 0..DEPTH.
//  - Order is preserved within each output. No ordering is defined between the two outputs.
//  - A word is never duplicated, dropped (except by Reset) or routed to the unselected output.
// TESTING
//  1 Reset: assert Reset 2 cycles with hyrja_valid = 1.
//    -> niveli0 = niveli1 = 0, both valids 0, and no push occurs.
//    -> hyrja_ready = 1 after Reset deasserts.
//  2 Routing: push 2'b01 with Sel = 0, then 2'b10 with Sel = 1, both outputs ready.
//    -> dalja0 = 01 valid 1 cycle after its push; dalja1 = 10 valid 1 cycle after its push.
//  3 Backpressure: dalja0_ready = 0; push 3, 2 with Sel = 0.
//    -> niveli0 = 2 and hyrja_ready = 0 for Sel = 0.
//    -> Switch Sel to 1: hyrja_ready = 1 the same cycle.
//    -> Release dalja0_ready: 3 then 2 appear in order.
//  4 Full push+pop: FIFO0 full, hyrja_valid = 1, Sel = 0, dalja0_ready = 1.
//    -> Pop only; niveli0 goes 2 -> 1; the new word is accepted the next cycle.
//  5 Wrap: stream 0,1,2,3,0,1,2,3 through FIFO1 with alternating ready.
//    -> Output order matches input exactly across ≥3 pointer wraps.
//  6 Reset mid-stream: FIFO0 holds 2 words and FIFO1 holds 1; assert Reset 1 cycle.
//    -> Both occupancies are 0 the next cycle; a pushed word then reappears after 1 cycle.

Source files
------------

// File: rtl/demux1n2_stream.sv
// demux1n2_stream: registered 1-to-2 stream demultiplexer.
// Sel steers each input word into one of two output FIFOs.
module demux1n2_stream #(
  parameter int W     = 2,
  parameter int DEPTH = 2
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [W-1:0]    hyrja,
  input  logic            hyrja_valid,
  output logic            hyrja_ready,
  input  logic            Sel,
  output logic [W-1:0]    dalja0,
  output logic            dalja0_valid,
  input  logic            dalja0_ready,
  output logic [W-1:0]    dalja1,
  output logic            dalja1_valid,
  input  logic            dalja1_ready,
  output logic [$clog2(DEPTH):0] niveli0,
  output logic [$clog2(DEPTH):0] niveli1
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULLN = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT1  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR1  = AW'(1);

  logic [1:0]          full;
  logic [1:0]          vld;
  logic [1:0]          push;
  logic [1:0]          pop;
  logic [1:0]          rdy;
  logic [2*W-1:0]      head;
  logic [2*(AW+1)-1:0] lvl;

  assign rdy = {dalja1_ready, dalja0_ready};

  // Only registered occupancy feeds ready: no path from consumer ready.
  assign hyrja_ready = !full[Sel];

  for (genvar g = 0; g < 2; g++) begin : g_q
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [AW:0]   cnt;

    assign full[g] = (cnt == FULLN);
    assign vld[g]  = (cnt != '0);
    assign push[g] = hyrja_valid
                   && (Sel == 1'(g))
                   && !full[g];
    assign pop[g]  = vld[g] && rdy[g];

    assign head[g*W +: W]       = vld[g] ? mem[rp] : '0;
    assign lvl[g*(AW+1) +: AW+1] = cnt;

    always_ff @(posedge Clock) begin
      if (push[g] && !Reset) begin
        mem[wp] <= hyrja;
      end
    end

    always_ff @(posedge Clock) begin
      if (Reset) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push[g]) begin
          wp <= wp + PTR1;
        end
        if (pop[g]) begin
          rp <= rp + PTR1;
        end
        unique case ({push[g], pop[g]})
          2'b10:   cnt <= cnt + CNT1;
          2'b01:   cnt <= cnt - CNT1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  assign dalja0       = head[W-1:0];
  assign dalja1       = head[2*W-1:W];
  assign dalja0_valid = vld[0];
  assign dalja1_valid = vld[1];
  assign niveli0      = lvl[AW:0];
  assign niveli1      = lvl[2*(AW+1)-1:AW+1];

endmodule

// File: tb/tb_demux1n2_stream.sv
// tb_demux1n2_stream: directed and random checks of demux1n2_stream
// against a queue-based model of the two output FIFOs.
module tb_demux1n2_stream;

  localparam int W = 2;
  localparam int D = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] din;
  logic       hv;
  logic       hr;
  logic       sel;
  logic [1:0] o0;
  logic       v0;
  logic       r0;
  logic [1:0] o1;
  logic       v1;
  logic       r1;
  logic [1:0] n0;
  logic [1:0] n1;

  int errors = 0;
  int checks = 0;

  logic [1:0] q0[$];
  logic [1:0] q1[$];

  demux1n2_stream #(.W(W), .DEPTH(D)) dut (
    .Clock(clk),
    .Reset(rst),
    .hyrja(din),
    .hyrja_valid(hv),
    .hyrja_ready(hr),
    .Sel(sel),
    .dalja0(o0),
    .dalja0_valid(v0),
    .dalja0_ready(r0),
    .dalja1(o1),
    .dalja1_valid(v1),
    .dalja1_ready(r1),
    .niveli0(n0),
    .niveli1(n1)
  );

  always #5 clk = ~clk;

  // Advance one clock and apply the same edge to the model.
  task automatic step();
    bit pu;
    bit p0;
    bit p1;
    logic [1:0] d;
    logic s;
    d  = din;
    s  = sel;
    pu = hv && (s ? q1.size() < D : q0.size() < D);
    p0 = (q0.size() != 0) && r0;
    p1 = (q1.size() != 0) && r1;
    @(posedge clk);
    if (rst) begin
      q0.delete();
      q1.delete();
    end else begin
      if (p0) void'(q0.pop_front());
      if (p1) void'(q1.pop_front());
      if (pu) begin
        if (s) q1.push_back(d);
        else   q0.push_back(d);
      end
    end
    #1;
  endtask

  task automatic idle_drain();
    hv = 0; r0 = 1; r1 = 1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1; hv = 1; sel = 0; din = 2'd3;
    r0 = 0; r1 = 0;
    step();
    step();
    checks++;
    if (n0 !== 2'd0) begin
      errors++;
      $display("FAIL reset_n0 got %0d want 0", n0);
    end
    checks++;
    if (n1 !== 2'd0) begin
      errors++;
      $display("FAIL reset_n1 got %0d want 0", n1);
    end
    checks++;
    if ({v0, v1} !== 2'b00) begin
      errors++;
      $display("FAIL reset_valid got %b want 00", {v0, v1});
    end
    rst = 0; hv = 0;
    #1;
    checks++;
    if (hr !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", hr);
    end
    step();
    checks++;
    if (n0 !== 2'd0 || v0 !== 1'b0) begin
      errors++;
      $display("FAIL reset_nopush n0=%0d v0=%b want 0 0", n0, v0);
    end
  endtask

  task automatic test_routing();
    r0 = 1; r1 = 1;
    hv = 1; sel = 0; din = 2'b01;
    step();
    hv = 1; sel = 1; din = 2'b10;
    #1;
    checks++;
    if (v0 !== 1'b1 || o0 !== 2'b01) begin
      errors++;
      $display("FAIL route0 got v=%b d=%b want 1 01", v0, o0);
    end
    checks++;
    if (v1 !== 1'b0) begin
      errors++;
      $display("FAIL route0_other got v1=%b want 0", v1);
    end
    step();
    hv = 0;
    #1;
    checks++;
    if (v1 !== 1'b1 || o1 !== 2'b10) begin
      errors++;
      $display("FAIL route1 got v=%b d=%b want 1 10", v1, o1);
    end
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL route1_other got v0=%b want 0", v0);
    end
    idle_drain();
  endtask

  task automatic test_backpressure();
    r0 = 0; r1 = 1;
    hv = 1; sel = 0; din = 2'd3;
    step();
    din = 2'd2;
    step();
    din = 2'd1;
    #1;
    checks++;
    if (n0 !== 2'd2) begin
      errors++;
      $display("FAIL bp_level got %0d want 2", n0);
    end
    checks++;
    if (hr !== 1'b0) begin
      errors++;
      $display("FAIL bp_ready0 got %b want 0", hr);
    end
    sel = 1;
    #1;
    checks++;
    if (hr !== 1'b1) begin
      errors++;
      $display("FAIL bp_ready1 got %b want 1", hr);
    end
    hv = 0; sel = 0; r0 = 1;
    #1;
    checks++;
    if (v0 !== 1'b1 || o0 !== 2'd3) begin
      errors++;
      $display("FAIL bp_first got v=%b d=%0d want 1 3", v0, o0);
    end
    step();
    checks++;
    if (v0 !== 1'b1 || o0 !== 2'd2) begin
      errors++;
      $display("FAIL bp_second got v=%b d=%0d want 1 2", v0, o0);
    end
    step();
    checks++;
    if (v0 !== 1'b0) begin
      errors++;
      $display("FAIL bp_empty got v=%b want 0", v0);
    end
    idle_drain();
  endtask

  task automatic test_full_push_pop();
    r0 = 0; hv = 1; sel = 0;
    din = 2'd1;
    step();
    din = 2'd2;
    step();
    din = 2'd3; r0 = 1;
    #1;
    checks++;
    if (hr !== 1'b0 || n0 !== 2'd2) begin
      errors++;
      $display("FAIL full_pre got rdy=%b n=%0d want 0 2", hr, n0);
    end
    step();
    checks++;
    if (n0 !== 2'd1 || hr !== 1'b1) begin
      errors++;
      $display("FAIL full_pop got n=%0d rdy=%b want 1 1", n0, hr);
    end
    checks++;
    if (o0 !== 2'd2) begin
      errors++;
      $display("FAIL full_head got %0d want 2", o0);
    end
    step();
    hv = 0;
    checks++;
    if (n0 !== 2'd1 || o0 !== 2'd3) begin
      errors++;
      $display("FAIL full_accept got n=%0d d=%0d want 1 3", n0, o0);
    end
    idle_drain();
  endtask

  task automatic test_wrap();
    logic [1:0] exp[$];
    logic [1:0] got[$];
    int idx = 0;
    int c;
    sel = 1; r0 = 1;
    for (int i = 0; i < 8; i++) exp.push_back(2'(i % 4));
    for (c = 0; c < 100 && got.size() < 8; c++) begin
      hv  = (idx < 8);
      din = 2'(idx % 4);
      r1  = c[0];
      #1;
      if (v1 && r1) got.push_back(o1);
      if (hv && hr) idx++;
      step();
    end
    hv = 0;
    checks++;
    if (got.size() != 8) begin
      errors++;
      $display("FAIL wrap_count got %0d want 8", got.size());
    end
    for (int i = 0; i < 8 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL wrap_word%0d got %0d want %0d",
                 i, got[i], exp[i]);
      end
    end
    idle_drain();
  endtask

  task automatic test_reset_mid();
    r0 = 0; r1 = 0; hv = 1;
    sel = 0; din = 2'd1;
    step();
    din = 2'd2;
    step();
    sel = 1; din = 2'd3;
    step();
    hv = 0;
    #1;
    checks++;
    if (n0 !== 2'd2 || n1 !== 2'd1) begin
      errors++;
      $display("FAIL mid_pre got %0d %0d want 2 1", n0, n1);
    end
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if (n0 !== 2'd0 || n1 !== 2'd0 || v0 || v1) begin
      errors++;
      $display("FAIL mid_reset got %0d %0d want 0 0", n0, n1);
    end
    hv = 1; sel = 0; din = 2'd2;
    step();
    hv = 0;
    #1;
    checks++;
    if (v0 !== 1'b1 || o0 !== 2'd2) begin
      errors++;
      $display("FAIL mid_after got v=%b d=%0d want 1 2", v0, o0);
    end
    idle_drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      hv  = 1'($urandom_range(0, 1));
      sel = 1'($urandom_range(0, 1));
      din = 2'($urandom_range(0, 3));
      r0  = ($urandom_range(0, 3) != 0);
      r1  = ($urandom_range(0, 2) == 0);
      rst = ($urandom_range(0, 99) == 0);
      #1;
      checks++;
      if (hr !== (sel ? q1.size() < D : q0.size() < D)) begin
        errors++;
        $display("FAIL rnd_ready c%0d got %b", c, hr);
      end
      checks++;
      if (n0 !== 2'(q0.size()) || n1 !== 2'(q1.size())) begin
        errors++;
        $display("FAIL rnd_level c%0d got %0d %0d want %0d %0d",
                 c, n0, n1, q0.size(), q1.size());
      end
      checks++;
      if (v0 !== (q0.size() != 0) || v1 !== (q1.size() != 0)) begin
        errors++;
        $display("FAIL rnd_valid c%0d got %b %b", c, v0, v1);
      end
      if (q0.size() != 0) begin
        checks++;
        if (o0 !== q0[0]) begin
          errors++;
          $display("FAIL rnd_head0 c%0d got %0d want %0d",
                   c, o0, q0[0]);
        end
      end
      if (q1.size() != 0) begin
        checks++;
        if (o1 !== q1[0]) begin
          errors++;
          $display("FAIL rnd_head1 c%0d got %0d want %0d",
                   c, o1, q1[0]);
        end
      end
      step();
    end
    rst = 0;
    idle_drain();
  endtask

  initial begin
    rst = 1; hv = 0; sel = 0; din = '0;
    r0 = 0; r1 = 0;
    #1;
    test_reset();
    test_routing();
    test_backpressure();
    test_full_push_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
